mem_wb_pipe: RTL and testbench

- Parametrised MEM/WB pipeline register for the RV32I core. Sits between the data-memory stage and register-file writeback.
- Adds the following to the plain MEM/WB latch:
  - valid tracking, stall (hold) and flush (bubble);
  - configurable stage depth;
  - load-data extraction with byte/half selection and sign/zero extension;
  - a final writeback mux and a retired-instruction counter.

---
 rtl/mem_wb_pipe.sv | 139 +++++++++++++
 tb/tb_mem_wb_pipe.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: MEM/WB pipeline register with valid/stall/flush, configurable depth,
// load-data extraction, writeback mux and retired-instruction counter.
//
// Ports:
//   clk, rst         falling-edge clock; asynchronous active-high reset
//   I_valid          input entry is a real instruction
//   I_stall          hold every stage
//   I_flush          clear every stage (wins over stall)
//   I_memReadData    aligned memory word
//   I_result         ALU result / load address
//   I_MemtoReg       writeback selects load data
//   I_MemRead        entry is a load
//   I_RegWrite       entry writes rd
//   I_writeRegister  rd index
//   I_funct3         load type (LB/LH/LW/LBU/LHU, others behave as LW)
//   O_valid          last stage holds a valid entry
//   O_wbData         final writeback value
//   O_result         registered ALU result
//   O_RegWrite       write enable qualified by valid and rd != x0
//   O_writeRegister  rd index
//   O_MemRead        registered load flag
//   O_misaligned     load address misaligned for its access size
//   O_retired        retired-instruction count (wraps)
module mem_wb_pipe #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int STAGES         = 1,
   parameter int CNT_WIDTH      = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      I_valid,
   input  logic                      I_stall,
   input  logic                      I_flush,
   input  logic [DATA_WIDTH-1:0]     I_memReadData,
   input  logic [DATA_WIDTH-1:0]     I_result,
   input  logic                      I_MemtoReg,
   input  logic                      I_MemRead,
   input  logic                      I_RegWrite,
   input  logic [REG_ADDR_WIDTH-1:0] I_writeRegister,
   input  logic [2:0]                I_funct3,
   output logic                      O_valid,
   output logic [DATA_WIDTH-1:0]     O_wbData,
   output logic [DATA_WIDTH-1:0]     O_result,
   output logic                      O_RegWrite,
   output logic [REG_ADDR_WIDTH-1:0] O_writeRegister,
   output logic                      O_MemRead,
   output logic                      O_misaligned,
   output logic [CNT_WIDTH-1:0]      O_retired
);
   localparam int L = STAGES - 1;

   logic                      validQ     [STAGES];
   logic                      memtoRegQ  [STAGES];
   logic                      memReadQ   [STAGES];
   logic                      regWriteQ  [STAGES];
   logic [REG_ADDR_WIDTH-1:0] writeRegQ  [STAGES];
   logic [2:0]                funct3Q    [STAGES];
   logic [DATA_WIDTH-1:0]     memDataQ   [STAGES];
   logic [DATA_WIDTH-1:0]     resultQ    [STAGES];
   logic [CNT_WIDTH-1:0]      retiredQ;

   // Flush clears data fields too, so a killed entry leaves nothing behind.
   always_ff @(negedge clk or posedge rst) begin
      if (rst || I_flush) begin
         for (int k = 0; k < STAGES; k++) begin
            validQ[k]    <= 1'b0;
            memtoRegQ[k] <= 1'b0;
            memReadQ[k]  <= 1'b0;
            regWriteQ[k] <= 1'b0;
            writeRegQ[k] <= '0;
            funct3Q[k]   <= '0;
            memDataQ[k]  <= '0;
            resultQ[k]   <= '0;
         end
      end else if (!I_stall) begin
         validQ[0]    <= I_valid;
         memtoRegQ[0] <= I_MemtoReg;
         memReadQ[0]  <= I_MemRead;
         regWriteQ[0] <= I_RegWrite;
         writeRegQ[0] <= I_writeRegister;
         funct3Q[0]   <= I_funct3;
         memDataQ[0]  <= I_memReadData;
         resultQ[0]   <= I_result;
         for (int k = 1; k < STAGES; k++) begin
            validQ[k]    <= validQ[k-1];
            memtoRegQ[k] <= memtoRegQ[k-1];
            memReadQ[k]  <= memReadQ[k-1];
            regWriteQ[k] <= regWriteQ[k-1];
            writeRegQ[k] <= writeRegQ[k-1];
            funct3Q[k]   <= funct3Q[k-1];
            memDataQ[k]  <= memDataQ[k-1];
            resultQ[k]   <= resultQ[k-1];
         end
      end
   end

   // The outgoing entry retires on any non-stalled edge, flush edges included.
   always_ff @(negedge clk or posedge rst) begin
      if (rst)
         retiredQ <= '0;
      else if (validQ[L] && !I_stall)
         retiredQ <= retiredQ + CNT_WIDTH'(1);
   end

   logic [1:0]            addrLow;
   logic [2:0]            lastFunct3;
   logic [DATA_WIDTH-1:0] lastData;
   logic [7:0]            loadByte;
   logic [15:0]           loadHalf;
   logic                  isByte;
   logic                  isHalf;
   logic                  isWord;
   logic                  isUnsigned;
   logic [DATA_WIDTH-1:0] loadData;

   assign addrLow    = resultQ[L][1:0];
   assign lastFunct3 = funct3Q[L];
   assign lastData   = memDataQ[L];
   assign loadByte   = lastData[{addrLow, 3'b000} +: 8];
   assign loadHalf   = lastData[{addrLow[1], 4'b0000} +: 16];
   // funct3[1:0] picks the size (00 byte, 01 half); anything else acts as a word.
   assign isByte     = lastFunct3[1:0] == 2'b00;
   assign isHalf     = lastFunct3[1:0] == 2'b01;
   assign isWord     = !isByte && !isHalf;
   assign isUnsigned = lastFunct3[2];
   assign loadData   = isByte ? {{(DATA_WIDTH-8){!isUnsigned && loadByte[7]}}, loadByte}
                     : isHalf ? {{(DATA_WIDTH-16){!isUnsigned && loadHalf[15]}}, loadHalf}
                     : lastData;

   assign O_valid         = validQ[L];
   assign O_wbData        = memtoRegQ[L] ? loadData : resultQ[L];
   assign O_result        = resultQ[L];
   assign O_RegWrite      = validQ[L] && regWriteQ[L] && (writeRegQ[L] != '0);
   assign O_writeRegister = writeRegQ[L];
   assign O_MemRead       = memReadQ[L];
   assign O_misaligned    = validQ[L] && memReadQ[L] && ((isHalf && addrLow[0]) || (isWord && |addrLow));
   assign O_retired       = retiredQ;
endmodule

// File: tb/tb_mem_wb_pipe.sv
// tb_mem_wb_pipe: directed self-checking bench for mem_wb_pipe (depth 1, depth 3, 4-bit counter).
module tb_mem_wb_pipe;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid = 1'b0, stall = 1'b0, flush = 1'b0;
   logic [31:0] memData = '0, result = '0;
   logic        memtoReg = 1'b0, memRead = 1'b0, regWrite = 1'b0;
   logic [4:0]  wreg = '0;
   logic [2:0]  funct3 = '0;

   logic        v1, rw1, mr1, mis1;
   logic [31:0] wb1, res1, ret1;
   logic [4:0]  wr1;
   logic        v3, rw3, mr3, mis3;
   logic [31:0] wb3, res3, ret3;
   logic [4:0]  wr3;
   logic        vW, rwW, mrW, misW;
   logic [31:0] wbW, resW;
   logic [3:0]  retW;
   logic [4:0]  wrW;

   int nChecks = 0;
   int nFail = 0;

   always #5 clk = ~clk;

   mem_wb_pipe #(.STAGES(1)) dut1 (
      .clk(clk), .rst(rst), .I_valid(valid), .I_stall(stall), .I_flush(flush),
      .I_memReadData(memData), .I_result(result), .I_MemtoReg(memtoReg), .I_MemRead(memRead),
      .I_RegWrite(regWrite), .I_writeRegister(wreg), .I_funct3(funct3),
      .O_valid(v1), .O_wbData(wb1), .O_result(res1), .O_RegWrite(rw1),
      .O_writeRegister(wr1), .O_MemRead(mr1), .O_misaligned(mis1), .O_retired(ret1));

   mem_wb_pipe #(.STAGES(3)) dut3 (
      .clk(clk), .rst(rst), .I_valid(valid), .I_stall(stall), .I_flush(flush),
      .I_memReadData(memData), .I_result(result), .I_MemtoReg(memtoReg), .I_MemRead(memRead),
      .I_RegWrite(regWrite), .I_writeRegister(wreg), .I_funct3(funct3),
      .O_valid(v3), .O_wbData(wb3), .O_result(res3), .O_RegWrite(rw3),
      .O_writeRegister(wr3), .O_MemRead(mr3), .O_misaligned(mis3), .O_retired(ret3));

   mem_wb_pipe #(.STAGES(1), .CNT_WIDTH(4)) dutW (
      .clk(clk), .rst(rst), .I_valid(valid), .I_stall(stall), .I_flush(flush),
      .I_memReadData(memData), .I_result(result), .I_MemtoReg(memtoReg), .I_MemRead(memRead),
      .I_RegWrite(regWrite), .I_writeRegister(wreg), .I_funct3(funct3),
      .O_valid(vW), .O_wbData(wbW), .O_result(resW), .O_RegWrite(rwW),
      .O_writeRegister(wrW), .O_MemRead(mrW), .O_misaligned(misW), .O_retired(retW));

   typedef struct {
      logic        valid, memtoReg, memRead, regWrite;
      logic [4:0]  wr;
      logic [2:0]  f3;
      logic [31:0] data, result, expWb;
      logic        expMis, expRw;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic setIn(input logic v, input logic m2r, input logic mr, input logic rw,
                        input logic [4:0] r, input logic [2:0] f, input logic [31:0] d,
                        input logic [31:0] res);
      valid = v; memtoReg = m2r; memRead = mr; regWrite = rw;
      wreg = r; funct3 = f; memData = d; result = res;
   endtask

   task automatic resetAll();
      rst = 1'b1;
      #3;
      rst = 1'b0;
   endtask

   initial begin
      logic [31:0] cnt;
      logic        prevValid;
      localparam logic [31:0] D = 32'h80FF7F01;
      vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 5'd5,  3'b000, D, 32'h10000003, 32'hFFFFFF80, 1'b0, 1'b1};
      vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 5'd6,  3'b100, D, 32'h10000002, 32'h000000FF, 1'b0, 1'b1};
      vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 5'd7,  3'b001, D, 32'h10000000, 32'h00007F01, 1'b0, 1'b1};
      vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 5'd8,  3'b101, D, 32'h10000002, 32'h000080FF, 1'b0, 1'b1};
      vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 5'd9,  3'b010, D, 32'h10000000, 32'h80FF7F01, 1'b0, 1'b1};
      vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 5'd10, 3'b001, D, 32'h10000001, 32'h00007F01, 1'b1, 1'b1};
      vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 5'd11, 3'b010, D, 32'h10000002, 32'h80FF7F01, 1'b1, 1'b1};
      vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 5'd12, 3'b001, D, 32'h00000003, 32'h00000003, 1'b0, 1'b1};
      vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 5'd0,  3'b000, D, 32'h00001234, 32'h00001234, 1'b0, 1'b0};
      vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 5'd13, 3'b001, D, 32'h10000002, 32'hFFFF80FF, 1'b0, 1'b1};
      vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 5'd3,  3'b010, D, 32'h10000001, 32'h80FF7F01, 1'b0, 1'b0};
      vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 5'd14, 3'b011, D, 32'h10000001, 32'h80FF7F01, 1'b1, 1'b1};

      #2;
      check("reset_valid", {31'b0, v1}, 32'd0);
      check("reset_wb", wb1, 32'd0);
      check("reset_retired", ret1, 32'd0);
      check("reset_valid3", {31'b0, v3}, 32'd0);
      rst = 1'b0;

      cnt = 0;
      prevValid = 1'b0;
      for (int i = 0; i < 12; i++) begin
         setIn(vecs[i].valid, vecs[i].memtoReg, vecs[i].memRead, vecs[i].regWrite,
               vecs[i].wr, vecs[i].f3, vecs[i].data, vecs[i].result);
         tick();
         if (prevValid) cnt++;
         prevValid = vecs[i].valid;
         check($sformatf("vec%0d_valid", i), {31'b0, v1}, {31'b0, vecs[i].valid});
         check($sformatf("vec%0d_wbData", i), wb1, vecs[i].expWb);
         check($sformatf("vec%0d_misaligned", i), {31'b0, mis1}, {31'b0, vecs[i].expMis});
         check($sformatf("vec%0d_RegWrite", i), {31'b0, rw1}, {31'b0, vecs[i].expRw});
         check($sformatf("vec%0d_result", i), res1, vecs[i].result);
         check($sformatf("vec%0d_writeRegister", i), {27'b0, wr1}, {27'b0, vecs[i].wr});
         check($sformatf("vec%0d_MemRead", i), {31'b0, mr1}, {31'b0, vecs[i].memRead});
         check($sformatf("vec%0d_retired", i), ret1, cnt);
      end

      // asynchronous reset mid-stream, sampled before any clock edge
      #2;
      rst = 1'b1;
      #1;
      check("midrst_valid", {31'b0, v1}, 32'd0);
      check("midrst_wb", wb1, 32'd0);
      check("midrst_result", res1, 32'd0);
      check("midrst_regwrite", {31'b0, rw1}, 32'd0);
      check("midrst_wreg", {27'b0, wr1}, 32'd0);
      check("midrst_memread", {31'b0, mr1}, 32'd0);
      check("midrst_misaligned", {31'b0, mis1}, 32'd0);
      check("midrst_retired", ret1, 32'd0);
      check("midrst_valid3", {31'b0, v3}, 32'd0);
      #1;
      rst = 1'b0;

      // stall / flush on the 3-deep pipe
      setIn(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 3'b000, 32'd0, 32'd0);
      tick();
      resetAll();
      setIn(1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 3'b000, 32'd0, 32'h0000000A);
      tick();
      setIn(1'b1, 1'b0, 1'b0, 1'b1, 5'd2, 3'b000, 32'd0, 32'h0000000B);
      tick();
      setIn(1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 3'b000, 32'd0, 32'h0000000C);
      stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         check($sformatf("stall%0d_valid", i), {31'b0, v3}, 32'd0);
         check($sformatf("stall%0d_retired", i), ret3, 32'd0);
      end
      stall = 1'b0;
      tick();
      check("release_valid", {31'b0, v3}, 32'd1);
      check("release_wb", wb3, 32'h0000000A);
      check("release_wreg", {27'b0, wr3}, 32'd1);
      check("release_regwrite", {31'b0, rw3}, 32'd1);
      check("release_retired", ret3, 32'd0);
      setIn(1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 3'b000, 32'd0, 32'h0000000D);
      stall = 1'b1;
      tick();
      check("heldA_valid", {31'b0, v3}, 32'd1);
      check("heldA_wb", wb3, 32'h0000000A);
      check("heldA_retired", ret3, 32'd0);
      stall = 1'b0;
      flush = 1'b1;
      tick();
      check("flush_valid", {31'b0, v3}, 32'd0);
      check("flush_regwrite", {31'b0, rw3}, 32'd0);
      check("flush_wb", wb3, 32'd0);
      check("flush_retired", ret3, 32'd1);
      flush = 1'b0;
      setIn(1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 3'b000, 32'd0, 32'h0000000E);
      tick();
      flush = 1'b1;
      stall = 1'b1;
      tick();
      check("flushstall_valid", {31'b0, v3}, 32'd0);
      check("flushstall_retired", ret3, 32'd1);
      flush = 1'b0;
      stall = 1'b0;
      setIn(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 3'b000, 32'd0, 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("drain%0d_valid", i), {31'b0, v3}, 32'd0);
         check($sformatf("drain%0d_retired", i), ret3, 32'd1);
      end

      // 4-bit counter wrap
      resetAll();
      for (int k = 1; k <= 17; k++) begin
         setIn(1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 3'b000, 32'd0, k);
         tick();
         if (k >= 2) check($sformatf("wrap_edge%0d", k), {28'b0, retW}, (k - 1) % 16);
      end
      setIn(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 3'b000, 32'd0, 32'd0);
      tick();
      check("wrap_edge18", {28'b0, retW}, 32'd1);
      tick();
      check("wrap_idle", {28'b0, retW}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end
endmodule
